// File: rtl/fifo_wr_ctrl.sv
// Write-side controller for the asynchronous FIFO: owns the binary/Gray write pointer and
// produces registered full, fill level, programmable almost-full and sticky overflow.
module fifo_wr_ctrl #(
  parameter int unsigned ADDR_SIZE = 4
) (
  input  logic                 wr_clk,
  input  logic                 wr_rst_n,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE:0]   rd_ptr_gray_sync,
  input  logic [ADDR_SIZE:0]   afull_thresh,
  input  logic                 ovf_clr,
  output logic                 wr_accept,
  output logic [ADDR_SIZE-1:0] wr_addr,
  output logic [ADDR_SIZE:0]   wr_ptr_gray,
  output logic                 full,
  output logic                 almost_full,
  output logic [ADDR_SIZE:0]   wr_level,
  output logic                 overflow
);

  localparam int unsigned PW = ADDR_SIZE + 1;

  logic [PW-1:0] wr_bin_q, wr_bin_d;
  logic [PW-1:0] gray_q, gray_d;
  logic [PW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] rd_full_cmp;

  // Gray to binary: XOR prefix starting from the MSB.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = '0;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_comb begin
    wr_accept   = wr_en & ~full_q;
    wr_bin_d    = wr_bin_q + PW'(wr_accept);
    gray_d      = (wr_bin_d >> 1) ^ wr_bin_d;
    rd_bin      = gray2bin(rd_ptr_gray_sync);
    // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
    rd_full_cmp = {~rd_ptr_gray_sync[ADDR_SIZE], ~rd_ptr_gray_sync[ADDR_SIZE-1],
                   rd_ptr_gray_sync[ADDR_SIZE-2:0]};
    full_d      = (gray_d == rd_full_cmp);
    level_d     = wr_bin_d - rd_bin;
    afull_d     = (level_d >= afull_thresh);
    // A rejected write on the same edge as a clear keeps the flag set.
    if (wr_en && full_q) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_bin_q <= '0;
      gray_q   <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_bin_q <= wr_bin_d;
      gray_q   <= gray_d;
      level_q  <= level_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
    end
  end

  assign wr_addr     = wr_bin_q[ADDR_SIZE-1:0];
  assign wr_ptr_gray = gray_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign wr_level    = level_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: randomized traffic against an occupancy-count model.
module tb_fifo_wr_ctrl;

  localparam int unsigned A     = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned PMOD  = 32;

  logic         wr_clk;
  logic         wr_rst_n;
  logic         wr_en;
  logic [A:0]   rd_ptr_gray_sync;
  logic [A:0]   afull_thresh;
  logic         ovf_clr;
  logic         wr_accept;
  logic [A-1:0] wr_addr;
  logic [A:0]   wr_ptr_gray;
  logic         full;
  logic         almost_full;
  logic [A:0]   wr_level;
  logic         overflow;

  int n_checks;
  int n_fail;

  // Model: total accepted writes and total reads published to the write side.
  int   wr_cnt;
  int   rd_cnt;
  logic m_full;
  logic m_afull;
  int   m_level;
  logic m_ovf;

  fifo_wr_ctrl #(.ADDR_SIZE(A)) dut (
    .wr_clk           (wr_clk),
    .wr_rst_n         (wr_rst_n),
    .wr_en            (wr_en),
    .rd_ptr_gray_sync (rd_ptr_gray_sync),
    .afull_thresh     (afull_thresh),
    .ovf_clr          (ovf_clr),
    .wr_accept        (wr_accept),
    .wr_addr          (wr_addr),
    .wr_ptr_gray      (wr_ptr_gray),
    .full             (full),
    .almost_full      (almost_full),
    .wr_level         (wr_level),
    .overflow         (overflow)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  function automatic logic [A:0] to_gray(input int x);
    logic [A:0] b;
    b = (A+1)'(x % PMOD);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [16:0] obs_vec();
    return {full, almost_full, wr_level, wr_ptr_gray, wr_addr, overflow};
  endfunction

  function automatic logic [16:0] exp_vec();
    return {m_full, m_afull, 5'(m_level), to_gray(wr_cnt), 4'(wr_cnt % DEPTH), m_ovf};
  endfunction

  task automatic model_reset();
    wr_cnt  = 0;
    rd_cnt  = 0;
    m_full  = 1'b0;
    m_afull = 1'b0;
    m_level = 0;
    m_ovf   = 1'b0;
  endtask

  // Apply inputs, take one clock edge, then advance the model by the same edge.
  task automatic drive_edge(input logic we, input logic clr);
    int occ;
    logic acc;
    wr_en            = we;
    ovf_clr          = clr;
    rd_ptr_gray_sync = to_gray(rd_cnt);
    @(posedge wr_clk);
    acc = we && !m_full;
    if (we && m_full) m_ovf = 1'b1;
    else if (clr)     m_ovf = 1'b0;
    if (acc) wr_cnt++;
    occ     = wr_cnt - rd_cnt;
    m_level = occ;
    m_full  = (occ == DEPTH);
    m_afull = (occ >= int'(afull_thresh));
    #1;
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic do_reset();
    wr_rst_n         = 1'b0;
    wr_en            = 1'b0;
    ovf_clr          = 1'b0;
    rd_ptr_gray_sync = '0;
    model_reset();
    repeat (2) @(posedge wr_clk);
    #1;
    wr_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    wr_rst_n         = 1'b0;
    ovf_clr          = 1'b0;
    rd_ptr_gray_sync = '0;
    afull_thresh     = 5'd0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'(i % 2);
      @(posedge wr_clk);
      #1;
      n_checks++;
      if (obs_vec() !== 17'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %h expected %h", obs_vec(), 17'd0);
      end
      n_checks++;
      if (wr_accept !== wr_en) begin
        n_fail++;
        $display("FAIL reset_accept: got %b expected %b", wr_accept, wr_en);
      end
    end
    wr_en = 1'b0;
    #1;
    wr_rst_n = 1'b1;
  endtask

  task automatic test_fill();
    afull_thresh = 5'd20;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive_edge(1'b1, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL fill_step%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if ({full, wr_level, wr_ptr_gray} !== {1'b1, 5'd16, 5'b11000}) begin
      n_fail++;
      $display("FAIL fill_full: got full=%b lvl=%0d gray=%b expected 1/16/11000",
               full, wr_level, wr_ptr_gray);
    end
    wr_en = 1'b1;
    #1;
    n_checks++;
    if (wr_accept !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_reject_accept: got %b expected 0", wr_accept);
    end
    drive_edge(1'b1, 1'b0);
    n_checks++;
    if ({overflow, wr_ptr_gray, wr_addr} !== {1'b1, 5'b11000, 4'd0}) begin
      n_fail++;
      $display("FAIL fill_overflow: got ovf=%b gray=%b addr=%0d expected 1/11000/0",
               overflow, wr_ptr_gray, wr_addr);
    end
  endtask

  task automatic test_almost_full();
    afull_thresh = 5'd14;
    do_reset();
    for (int i = 0; i < 13; i++) drive_edge(1'b1, 1'b0);
    n_checks++;
    if (almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL afull_at13: got %b expected 0", almost_full);
    end
    drive_edge(1'b1, 1'b0);
    n_checks++;
    if ({almost_full, wr_level} !== {1'b1, 5'd14}) begin
      n_fail++;
      $display("FAIL afull_at14: got af=%b lvl=%0d expected 1/14", almost_full, wr_level);
    end
    rd_cnt = 2;
    drive_edge(1'b0, 1'b0);
    n_checks++;
    if ({almost_full, wr_level} !== {1'b0, 5'd12}) begin
      n_fail++;
      $display("FAIL afull_read: got af=%b lvl=%0d expected 0/12", almost_full, wr_level);
    end
  endtask

  task automatic test_wrap();
    logic saw_wrap;
    logic [A:0] prev_gray;
    afull_thresh = 5'd10;
    saw_wrap = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) drive_edge(1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      prev_gray = wr_ptr_gray;
      rd_cnt = wr_cnt - 3;
      drive_edge(1'b1, 1'b0);
      if (prev_gray == 5'b10000 && wr_ptr_gray == 5'b00000) saw_wrap = 1'b1;
      n_checks++;
      if (obs_vec() !== exp_vec() || full !== 1'b0 || wr_level !== 5'd4) begin
        n_fail++;
        $display("FAIL wrap_step%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (saw_wrap !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_gray_msb: got saw_wrap=%b expected 1", saw_wrap);
    end
  endtask

  task automatic test_overflow_clear();
    afull_thresh = 5'd16;
    do_reset();
    for (int i = 0; i < 16; i++) drive_edge(1'b1, 1'b0);
    drive_edge(1'b1, 1'b1);
    n_checks++;
    if ({overflow, full} !== 2'b11) begin
      n_fail++;
      $display("FAIL ovf_set_wins: got ovf=%b full=%b expected 1/1", overflow, full);
    end
    drive_edge(1'b0, 1'b1);
    n_checks++;
    if (obs_vec() !== exp_vec() || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      afull_thresh = 5'($urandom_range(0, 20));
      do_reset();
      for (int i = 0; i < 150; i++) begin
        logic we;
        logic clr;
        we  = ($urandom_range(0, 99) < 60);
        clr = ($urandom_range(0, 9) == 0);
        if (rd_cnt < wr_cnt && $urandom_range(0, 99) < 40) rd_cnt++;
        #1;
        n_checks++;
        wr_en = we;
        rd_ptr_gray_sync = to_gray(rd_cnt);
        #1;
        if (wr_accept !== (we && !m_full)) begin
          n_fail++;
          $display("FAIL rand_accept r%0d i%0d: got %b expected %b", r, i, wr_accept, we && !m_full);
        end
        drive_edge(we, clr);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL rand_state r%0d i%0d: got %h expected %h", r, i, obs_vec(), exp_vec());
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    afull_thresh = 5'd5;
    do_reset();
    for (int i = 0; i < 9; i++) drive_edge(1'b1, 1'b0);
    n_checks++;
    if (wr_level !== 5'd9) begin
      n_fail++;
      $display("FAIL rstmid_level: got %0d expected 9", wr_level);
    end
    #2;
    wr_rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs_vec() !== 17'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: got %h expected %h", obs_vec(), 17'd0);
    end
    model_reset();
    @(posedge wr_clk);
    #1;
    wr_rst_n = 1'b1;
    wr_en = 1'b1;
    #1;
    n_checks++;
    if ({wr_accept, wr_addr} !== {1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL rstmid_first_addr: got acc=%b addr=%0d expected 1/0", wr_accept, wr_addr);
    end
    drive_edge(1'b1, 1'b0);
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL rstmid_first_write: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_fill();
    test_almost_full();
    test_wrap();
    test_overflow_clear();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
